// File: rtl/freq_meas_pkg.sv
// Shared types and helpers for the frequency-measurement sequencer.
package freq_meas_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_EVAL,
    S_SETTLE,
    S_GATE,
    S_CALC
  } state_e;

  localparam logic [31:0] SAT32 = 32'hFFFF_FFFF;

  // Hz per counted edge; the gate length must divide the clock rate exactly.
  function automatic int unsigned freq_scale(input int unsigned clk_hz,
                                             input int unsigned gate_cycles);
    return clk_hz / gate_cycles;
  endfunction

endpackage

// File: rtl/freq_meas_ctrl_if.sv
// Signal bundle between the sample/comparator front end and the measurement sequencer.
interface freq_meas_ctrl_if;
  logic [7:0]  data_in;
  logic        edge_pulse;
  logic        start;
  logic        abort;
  logic        cont_mode;
  logic [7:0]  trig_level;
  logic        gate;
  logic        busy;
  logic [31:0] freq;
  logic        freq_valid;
  logic        no_signal;

  modport master (
    output data_in, edge_pulse, start, abort, cont_mode,
    input  trig_level, gate, busy, freq, freq_valid, no_signal
  );

  modport slave (
    input  data_in, edge_pulse, start, abort, cont_mode,
    output trig_level, gate, busy, freq, freq_valid, no_signal
  );
endinterface

// File: rtl/minmax_tracker.sv
// Running min/max of the ADC stream; clr restarts the window, en admits a sample.
module minmax_tracker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] min_o,
  output logic [7:0] max_o
);

  logic [7:0] min_q, max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= 8'hFF;
      max_q <= 8'h00;
    end else if (clr_i) begin
      min_q <= 8'hFF;
      max_q <= 8'h00;
    end else if (en_i) begin
      if (data_i < min_q) min_q <= data_i;
      if (data_i > max_q) max_q <= data_i;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Frequency-measurement sequencer: min/max scan, trigger midpoint, fixed gate, scale to Hz.
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned GATE_CYCLES   = 50_000_000,
  parameter int unsigned SCAN_CYCLES   = 65_536,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  MIN_SWING     = 8'd32
) (
  input logic             clk,
  input logic             rst_n,
  freq_meas_ctrl_if.slave bus
);

  localparam int unsigned FREQ_SCALE  = freq_scale(CLK_HZ, GATE_CYCLES);
  localparam logic [31:0] SCAN_LOAD   = 32'(SCAN_CYCLES - 1);
  localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] GATE_LOAD   = 32'(GATE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] edge_cnt_q, edge_cnt_d;
  logic [31:0] freq_q, freq_d;
  logic [7:0]  trig_q, trig_d;
  logic        gate_q, gate_d;
  logic        fv_q, fv_d;
  logic        ns_q, ns_d;
  logic        clr, en;
  logic [7:0]  min_w, max_w, swing;
  logic [8:0]  mid_sum;
  logic [63:0] prod;

  minmax_tracker u_minmax (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .en_i   (en),
    .data_i (bus.data_in),
    .min_o  (min_w),
    .max_o  (max_w)
  );

  assign swing   = max_w - min_w;
  assign mid_sum = {1'b0, max_w} + {1'b0, min_w};
  assign prod    = {32'd0, edge_cnt_q} * 64'(FREQ_SCALE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      freq_q     <= '0;
      trig_q     <= 8'd128;
      gate_q     <= 1'b0;
      fv_q       <= 1'b0;
      ns_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      freq_q     <= freq_d;
      trig_q     <= trig_d;
      gate_q     <= gate_d;
      fv_q       <= fv_d;
      ns_q       <= ns_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q != '0) ? cnt_q - 32'd1 : cnt_q;
    edge_cnt_d = edge_cnt_q;
    freq_d     = freq_q;
    trig_d     = trig_q;
    gate_d     = 1'b0;
    fv_d       = 1'b0;
    ns_d       = ns_q;
    clr        = 1'b0;
    en         = 1'b0;

    // gate_q is the registered window itself, so the last gate cycle still counts.
    if (gate_q && bus.edge_pulse && edge_cnt_q != SAT32) edge_cnt_d = edge_cnt_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SCAN;
          cnt_d   = SCAN_LOAD;
          clr     = 1'b1;
        end
      end
      S_SCAN: begin
        en = 1'b1;
        if (cnt_q == '0) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (swing < MIN_SWING) begin
          ns_d   = 1'b1;
          freq_d = '0;
          fv_d   = 1'b1;
          if (bus.cont_mode) begin
            state_d = S_SCAN;
            cnt_d   = SCAN_LOAD;
            clr     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ns_d    = 1'b0;
          trig_d  = mid_sum[8:1];
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_GATE;
          cnt_d   = GATE_LOAD;
          gate_d  = 1'b1;
        end
      end
      S_GATE: begin
        gate_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_CALC;
          gate_d  = 1'b0;
        end
      end
      S_CALC: begin
        freq_d     = (prod[63:32] != '0) ? SAT32 : prod[31:0];
        fv_d       = 1'b1;
        edge_cnt_d = '0;
        if (bus.cont_mode) begin
          state_d = S_SCAN;
          cnt_d   = SCAN_LOAD;
          clr     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every advance and discards the partial result.
    if (bus.abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      edge_cnt_d = '0;
      freq_d     = freq_q;
      trig_d     = trig_q;
      gate_d     = 1'b0;
      fv_d       = 1'b0;
      ns_d       = ns_q;
      clr        = 1'b0;
      en         = 1'b0;
    end
  end

  assign bus.trig_level = trig_q;
  assign bus.gate       = gate_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.freq       = freq_q;
  assign bus.freq_valid = fv_q;
  assign bus.no_signal  = ns_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Scoreboard bench for freq_meas_ctrl with a window-arithmetic reference model.
module tb_freq_meas_ctrl;

  localparam int CLK_HZ = 1_000_000;
  localparam int GATE   = 1000;
  localparam int SCAN   = 64;
  localparam int SETTLE = 4;
  localparam int SCALE  = CLK_HZ / GATE;
  localparam int RUN    = SCAN + 1 + SETTLE + GATE + 1;
  localparam int G0     = SCAN + 1 + SETTLE + 1;
  localparam int G1     = G0 + GATE - 1;
  localparam int TAIL   = 6;
  localparam int MAXLEN = 3 * RUN + TAIL + 4;

  typedef struct {
    logic [31:0] freq;
    logic        ns;
    logic [7:0]  trig;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb[$];
  int   vtimes[$];
  exp_t mon_e;

  logic [7:0] data_arr [MAXLEN];
  bit         edge_arr [MAXLEN];
  logic [7:0] m_trig = 8'd128;
  logic [31:0] m_freq = '0;
  logic       m_ns = 1'b0;

  freq_meas_ctrl_if bus ();

  freq_meas_ctrl #(
    .CLK_HZ        (CLK_HZ),
    .GATE_CYCLES   (GATE),
    .SCAN_CYCLES   (SCAN),
    .SETTLE_CYCLES (SETTLE),
    .MIN_SWING     (8'd32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_trig"},  longint'(bus.trig_level), 128);
    check({tag, "_gate"},  longint'(bus.gate), 0);
    check({tag, "_busy"},  longint'(bus.busy), 0);
    check({tag, "_freq"},  longint'(bus.freq), 0);
    check({tag, "_fv"},    longint'(bus.freq_valid), 0);
    check({tag, "_nosig"}, longint'(bus.no_signal), 0);
  endtask

  // Monitor: every freq_valid pulse consumes the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && bus.freq_valid === 1'b1) begin
      vtimes.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_freq_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("freq",       longint'(bus.freq),       longint'(mon_e.freq));
        check("no_signal",  longint'(bus.no_signal),  longint'(mon_e.ns));
        check("trig_level", longint'(bus.trig_level), longint'(mon_e.trig));
      end
    end
  end

  // dk: 0 square 40/200, 1 flat 100+-5, 2 wide random, 3 random swing
  // ek: 0 every 20 cycles, 1 gate boundaries, 2 random, 3 none
  // ik: 0 none, 1 abort at offset iat, 2 reset at offset iat
  task automatic run_batch(input int nruns, input int dk, input int ek,
                           input int ik, input int iat);
    int base, len_r, lo, hi, period, mn, mx, d, cnt, total, v0, start_cyc;
    int gate_bad, busy_bad, last_base;
    int lens[$];
    exp_t pend[$];
    exp_t e;
    logic [7:0] cur_trig;
    bit eg [MAXLEN];
    bit eb [MAXLEN];

    lo = 0; hi = 255;
    if (dk == 2) begin
      lo = int'($urandom_range(100, 0));
      hi = int'($urandom_range(255, lo + 60));
    end else if (dk == 3) begin
      lo = int'($urandom_range(200, 0));
      hi = lo + int'($urandom_range(55, 0));
      if (hi > 255) hi = 255;
    end
    period = int'($urandom_range(30, 2));
    for (int k = 0; k < MAXLEN; k++) begin
      case (dk)
        0:       data_arr[k] = (((k / 10) % 2) == 1) ? 8'd200 : 8'd40;
        1:       data_arr[k] = 8'($urandom_range(105, 95));
        default: data_arr[k] = 8'($urandom_range(hi, lo));
      endcase
      case (ek)
        0:       edge_arr[k] = ((k % 20) == 0);
        1:       edge_arr[k] = (k == G0 - 1) || (k == G0) || (k == G1) || (k == G1 + 1);
        2:       edge_arr[k] = ($urandom_range(period - 1, 0) == 0);
        default: edge_arr[k] = 1'b0;
      endcase
      eg[k] = 1'b0;
      eb[k] = 1'b0;
    end

    // Reference: samples at offsets 1..SCAN after start, gate at offsets G0..G1.
    base = 0; last_base = 0; cur_trig = m_trig;
    for (int r = 0; r < nruns; r++) begin
      mn = 255; mx = 0;
      for (int i = 1; i <= SCAN; i++) begin
        d = int'(data_arr[base + i]);
        if (d < mn) mn = d;
        if (d > mx) mx = d;
      end
      if (mx - mn < 32) begin
        e.freq = '0; e.ns = 1'b1; e.trig = cur_trig;
        len_r = SCAN + 1;
      end else begin
        cur_trig = 8'((mx + mn) / 2);
        cnt = 0;
        for (int i = G0; i <= G1; i++) begin
          cnt += int'(edge_arr[base + i]);
          eg[base + i] = 1'b1;
        end
        e.freq = 32'(cnt * SCALE); e.ns = 1'b0; e.trig = cur_trig;
        len_r = RUN;
      end
      for (int i = 1; i <= len_r; i++) eb[base + i] = 1'b1;
      pend.push_back(e);
      lens.push_back(len_r);
      last_base = base;
      base += len_r;
    end
    total = base;

    if (ik == 1) begin
      for (int k = iat + 1; k < MAXLEN; k++) begin
        eg[k] = 1'b0;
        eb[k] = 1'b0;
      end
    end
    if (ik == 0) begin
      foreach (pend[i]) sb.push_back(pend[i]);
      m_trig = cur_trig;
      m_freq = pend[pend.size() - 1].freq;
      m_ns   = pend[pend.size() - 1].ns;
    end

    v0 = vtimes.size(); gate_bad = 0; busy_bad = 0; start_cyc = 0;
    for (int k = 0; k < total + TAIL; k++) begin
      @(negedge clk);
      if (bus.gate !== eg[k]) gate_bad++;
      if (bus.busy !== eb[k]) busy_bad++;
      if (ik == 1 && k == iat + 1) begin
        check("abort_gate_low", longint'(bus.gate), 0);
        check("abort_busy_low", longint'(bus.busy), 0);
      end
      if (k == 0) start_cyc = cyc;
      bus.data_in    = data_arr[k];
      bus.edge_pulse = edge_arr[k];
      bus.start      = (k == 0);
      bus.cont_mode  = (nruns > 1) && (k <= last_base);
      bus.abort      = (ik == 1) && (k == iat);
      if (ik == 2 && k == iat) begin
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        #1 check_reset_vals("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        m_trig = 8'd128; m_freq = '0; m_ns = 1'b0;
        break;
      end
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.edge_pulse = 1'b0; bus.cont_mode = 1'b0;

    check("gate_window_errs", longint'(gate_bad), 0);
    check("busy_window_errs", longint'(busy_bad), 0);
    check("valid_count", longint'(vtimes.size() - v0), (ik == 0) ? longint'(nruns) : 0);
    if (ik == 0 && vtimes.size() >= v0 + nruns) begin
      check("latency", longint'(vtimes[v0] - start_cyc), longint'(lens[0] + 1));
      for (int r = 1; r < nruns; r++)
        check("valid_spacing", longint'(vtimes[v0 + r] - vtimes[v0 + r - 1]), longint'(lens[r]));
    end
    if (ik == 1) begin
      check("abort_freq_hold",  longint'(bus.freq), longint'(m_freq));
      check("abort_nosig_hold", longint'(bus.no_signal), longint'(m_ns));
    end
  endtask

  initial begin
    bus.data_in = 8'd0; bus.edge_pulse = 1'b0; bus.start = 1'b0;
    bus.abort = 1'b0; bus.cont_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset");

    // Flat input: no_signal, zero freq, no gate, trigger untouched.
    run_batch(1, 1, 0, 0, 0);
    check("flat_trig", longint'(bus.trig_level), 128);
    check("flat_nosig", longint'(bus.no_signal), 1);

    // Square wave 40..200 with 50 edges in the gate.
    run_batch(1, 0, 0, 0, 0);
    check("sq_trig", longint'(bus.trig_level), 120);
    check("sq_freq", longint'(bus.freq), 50000);
    check("sq_nosig", longint'(bus.no_signal), 0);

    // Abort at gate cycle 500: freq keeps 50000.
    run_batch(1, 0, 0, 1, G0 + 499);
    check("abort_freq_50k", longint'(bus.freq), 50000);

    // Edges one before, first, last and one after the gate.
    run_batch(1, 0, 1, 0, 0);
    check("boundary_freq", longint'(bus.freq), 2 * SCALE);

    // Continuous mode, three back-to-back runs.
    run_batch(3, 2, 2, 0, 0);

    for (int i = 0; i < 4; i++) run_batch(1, 3, 2, 0, 0);

    run_batch(1, 2, 2, 0, 0);
    run_batch(1, 2, 2, 2, 30);
    run_batch(1, 2, 2, 0, 0);
    run_batch(1, 2, 2, 2, G0 + 500);
    run_batch(1, 0, 0, 0, 0);
    check("post_rst_freq", longint'(bus.freq), 50000);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", longint'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
